// File: rtl/axi_rd_pkg.sv
// Shared definitions for the read-channel arbiter: AXI IDs, burst encoding and AR state.
package axi_rd_pkg;

    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

endpackage

// File: rtl/rd_out_ctr.sv
// Outstanding-read counter for one AXI ID; saturating range is 0..MAX_OUT.
module rd_out_ctr #(
    parameter int MAX_OUT = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;

    // Simultaneous issue and retire on the same ID cancel out.
    always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec) begin
            cnt_next = cnt_reg + 3'd1;
        end else if (dec && !inc) begin
            cnt_next = cnt_reg - 3'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_reg <= 3'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign full  = (cnt_reg == 3'(MAX_OUT));
    assign empty = (cnt_reg == 3'd0);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 AR/R channel pair between the inst-fetch and data-load sram-like ports.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rd_err
);

    // Requester index 0 is inst, 1 is data, matching the AXI ID values.
    logic [1:0]        req_vec;
    logic [1:0]        full_vec;
    logic [1:0]        empty_vec;
    logic [1:0]        elig_vec;
    logic [1:0]        grant_vec;
    logic [1:0]        addr_ok_vec;
    logic [1:0]        beat_ok_vec;
    logic [1:0]        retire_vec;
    logic [1:0]        data_ok_reg;
    logic [1:0][31:0]  rdata_reg;

    ar_state_e   state_reg;
    ar_state_e   state_next;
    logic        last_data_reg;
    logic [3:0]  arid_reg;
    logic [31:0] araddr_reg;
    logic [2:0]  arsize_reg;
    logic [1:0]  arburst_reg;
    logic        rready_reg;
    logic        rd_err_reg;
    logic        r_hs;

    assign req_vec  = {data_req, inst_req};
    assign elig_vec = req_vec & ~full_vec;

    // Contention goes to whoever was not granted last; a lone eligible requester wins outright.
    always_comb begin
        grant_vec = elig_vec;
        if (elig_vec == 2'b11) begin
            grant_vec = last_data_reg ? 2'b01 : 2'b10;
        end
    end

    assign addr_ok_vec  = (state_reg == AR_IDLE) ? grant_vec : 2'b00;
    assign inst_addr_ok = addr_ok_vec[0];
    assign data_addr_ok = addr_ok_vec[1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            AR_IDLE: if (|addr_ok_vec) state_next = AR_BUSY;
            AR_BUSY: if (arready)      state_next = AR_IDLE;
            default: state_next = AR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= AR_IDLE;
            last_data_reg <= 1'b0;
            arid_reg      <= 4'd0;
            araddr_reg    <= 32'd0;
            arsize_reg    <= 3'd0;
            arburst_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            if (|addr_ok_vec) begin
                last_data_reg <= addr_ok_vec[1];
                arid_reg      <= addr_ok_vec[1] ? ID_DATA : ID_INST;
                araddr_reg    <= addr_ok_vec[1] ? data_addr : inst_addr;
                arsize_reg    <= {1'b0, (addr_ok_vec[1] ? data_size : inst_size)};
                arburst_reg   <= BURST_INCR;
            end
        end
    end

    assign arvalid = (state_reg == AR_BUSY);
    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arsize  = arsize_reg;
    assign arburst = arburst_reg;
    assign arlen   = 8'd0;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign r_hs = rvalid && rready_reg;

    // A beat is only delivered when its ID is known and something is outstanding on it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign beat_ok_vec[gi] = r_hs && (rid == 4'(gi)) && !empty_vec[gi];
            assign retire_vec[gi]  = beat_ok_vec[gi] && rlast;

            rd_out_ctr #(.MAX_OUT(MAX_OUT)) u_ctr (
                .aclk    (aclk),
                .aresetn (aresetn),
                .inc     (addr_ok_vec[gi]),
                .dec     (retire_vec[gi]),
                .full    (full_vec[gi]),
                .empty   (empty_vec[gi])
            );

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    data_ok_reg[gi] <= 1'b0;
                    rdata_reg[gi]   <= 32'd0;
                end else begin
                    data_ok_reg[gi] <= beat_ok_vec[gi];
                    if (beat_ok_vec[gi]) begin
                        rdata_reg[gi] <= rdata;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rready_reg <= 1'b0;
            rd_err_reg <= 1'b0;
        end else begin
            rready_reg <= 1'b1;
            if (r_hs && ((rresp != 2'b00) || !(|beat_ok_vec))) begin
                rd_err_reg <= 1'b1;
            end
        end
    end

    assign rready       = rready_reg;
    assign rd_err       = rd_err_reg;
    assign inst_data_ok = data_ok_reg[0];
    assign data_data_ok = data_ok_reg[1];
    assign inst_rdata   = rdata_reg[0];
    assign data_rdata   = rdata_reg[1];

endmodule
